fb_plot_sink: RTL
=================

# fb_plot_sink

Receiving end of the pixel-plot interface driven by fillscreen and the other drawing engines. It captures every vga_plot strobe into an on-chip WIDTH×HEIGHT frame buffer, supports a hardware clear, and streams the stored frame back out in raster order over a valid/ready port. Self-checking benches use it to compare a drawing engine's output against expected images; it is also the software-visible frame store for readback.

## Interface
- WIDTH, 160, frame width in pixels
- HEIGHT, 120, frame height in pixels
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  reset, asynchronous, active-high; single clock domain
- vga_x  in  8  plot x coordinate
- vga_y  in  7  plot y coordinate
- vga_colour  in  3  plot colour
- vga_plot  in  1  write strobe, one pixel per high cycle
- clear  in  1  pulse: fill buffer with colour 0
- rd_start  in  1  pulse: begin raster readback
- rd_ready  in  1  downstream accepts current pixel
- rd_x  out  8  readback x
- rd_y  out  7  readback y
- rd_colour  out  3  readback colour
- rd_valid  out  1  readback pixel valid
- busy  out  1  high in CLEAR or READ
- done  out  1  one-cycle pulse at end of a clear or a readback
- plot_count  out  15  accepted plots since last clear, saturating at 32767
- drop_err  out  1  sticky: a plot was dropped

## Operation
- States: IDLE, CLEAR, READ. Reset enters IDLE; all outputs 0.
- IDLE: clear → CLEAR; else rd_start → READ. If both are asserted, clear wins and rd_start is ignored. Both pulses are ignored outside IDLE.
- Plot write: address = y*WIDTH + x. The write happens in the same cycle as vga_plot in IDLE and READ; plot_count increments.
- Plot in CLEAR: not written, not counted, sets drop_err.
- Plot to the address being read in the same cycle: the read returns the old data.
- CLEAR:
  - Walks addresses 0 to WIDTH*HEIGHT-1, one per cycle, writing 0.
  - plot_count and drop_err are zeroed on entry.
  - After the last write: done pulse, return to IDLE.
- READ:
  - Walks addresses in raster order, x fastest, x wraps WIDTH-1→0 and increments y.
  - rd_x, rd_y and rd_colour stay stable while rd_valid && !rd_ready.
  - A pixel transfers on rd_valid && rd_ready.
  - After (WIDTH-1, HEIGHT-1) transfers: rd_valid drops, done pulses, return to IDLE.
- Memory contents are not reset. Contents are undefined until the first clear.

## Timing
- Memory is simple dual-port with 1-cycle registered read; a 2-entry skid buffer provides full throughput.
- rd_start at cycle n: first rd_valid at n+2. With rd_ready held high, one pixel transfers per cycle; done at cycle n+2+WIDTH*HEIGHT.
- clear at cycle n: busy from n+1; done at n+1+WIDTH*HEIGHT (19200 cycles for defaults).
- plot_count updates the cycle after the strobe.
- rst asserted mid-CLEAR or mid-READ: immediate IDLE. rd_valid, busy, done, plot_count and drop_err go to 0. Buffer contents are left partial.

## Configuration
- FB_BOUNDS_CHECK_EN defined:
  - A plot with x ≥ WIDTH or y ≥ HEIGHT is not written or counted, and sets drop_err.
- FB_BOUNDS_CHECK_EN not defined:
  - No range check; the address is computed modulo WIDTH*HEIGHT.
  - Out-of-range plots write and count.
  - drop_err is set only by plots during CLEAR.

## Structure
- Shared package fb_pkg holds:
  - the state enum (IDLE, CLEAR, READ);
  - FB_WIDTH, FB_HEIGHT and FB_DEPTH;
  - the colour width;
  - the address-compute function.
- One sub-module, fb_ram: simple dual-port RAM, WIDTH*HEIGHT×3, synchronous write, 1-cycle registered read.
- The FSM, counters and skid buffer live in fb_plot_sink.

## Test plan
- rst, clear, then a fillscreen-style sweep plotting colour x%8 at every pixel, then rd_start with rd_ready=1 → 19200 pixels, each with colour rd_x%8. plot_count=19200, done pulses once, drop_err=0.
- Single plot (5,7,colour 6), then readback → only pixel (5,7) reads 6, all others 0. plot_count=1.
- Readback with rd_ready toggling 1/0 every cycle → no pixel lost or duplicated. Outputs hold during stall; total transfers 19200.
- Plot during CLEAR → drop_err=1 and plot_count=0 after done. clear and rd_start in the same cycle → CLEAR only.
- With FB_BOUNDS_CHECK_EN, plot at (160,0) → drop_err=1, plot_count unchanged, pixel (0,1) still 0. Without the macro, pixel (0,1) takes the colour.
- rst asserted 100 cycles into READ → next cycle rd_valid=0 and busy=0. A subsequent rd_start restarts the readback at (0,0).

Source files
------------

// File: rtl/fb_pkg.sv
// rtl/fb_pkg.sv - frame-buffer constants, FSM state enum and pixel address helper
// Shared by fb_ram and fb_plot_sink.
package fb_pkg;
   localparam int FB_WIDTH  = 160;
   localparam int FB_HEIGHT = 120;
   localparam int FB_DEPTH  = FB_WIDTH * FB_HEIGHT;
   localparam int COLOUR_W  = 3;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      CLEAR = 2'd1,
      READ  = 2'd2
   } fb_state_t;

   // Linear raster address, folded into the frame so any coordinate lands in memory.
   function automatic int unsigned fb_addr(input logic [7:0] x, input logic [6:0] y,
                                           input int unsigned width, input int unsigned depth);
      return (32'(y) * width + 32'(x)) % depth;
   endfunction
endpackage

// File: rtl/fb_ram.sv
// rtl/fb_ram.sv - simple dual-port frame store, synchronous write, registered read
// rdata holds while re is low; a same-address write returns the old word.
module fb_ram
   import fb_pkg::*;
#(
   parameter int DEPTH = FB_DEPTH,
   parameter int AW    = $clog2(DEPTH),
   parameter int DW    = COLOUR_W
) (
   input  logic          clk,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  logic [DW-1:0] wdata,
   input  logic          re,
   input  logic [AW-1:0] raddr,
   output logic [DW-1:0] rdata
);
   logic [DW-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
      if (re) rdata <= mem[raddr];
   end
endmodule

// File: rtl/fb_plot_sink.sv
// rtl/fb_plot_sink.sv - plot capture frame buffer with hardware clear and raster readback
// Optional FB_BOUNDS_CHECK_EN: drop (and flag) plots outside the frame instead of folding them.
module fb_plot_sink
   import fb_pkg::*;
#(
   parameter int WIDTH  = FB_WIDTH,
   parameter int HEIGHT = FB_HEIGHT
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [7:0]          vga_x,
   input  logic [6:0]          vga_y,
   input  logic [COLOUR_W-1:0] vga_colour,
   input  logic                vga_plot,
   input  logic                clear,
   input  logic                rd_start,
   input  logic                rd_ready,
   output logic [7:0]          rd_x,
   output logic [6:0]          rd_y,
   output logic [COLOUR_W-1:0] rd_colour,
   output logic                rd_valid,
   output logic                busy,
   output logic                done,
   output logic [14:0]         plot_count,
   output logic                drop_err
);
   localparam int            DEPTH     = WIDTH * HEIGHT;
   localparam int            AW        = $clog2(DEPTH);
   localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);
   localparam logic [7:0]    LAST_X    = 8'(WIDTH - 1);
   localparam logic [6:0]    LAST_Y    = 7'(HEIGHT - 1);

   fb_state_t           state, state_next;
   logic                done_next;
   logic [AW-1:0]       clr_addr, iss_addr;
   logic [7:0]          iss_x, a_x, s_x;
   logic [6:0]          iss_y, a_y, s_y;
   logic                iss_more, a_valid, s_valid;
   logic [COLOUR_W-1:0] s_colour, ram_rdata;
   logic                re, xfer, in_range, plot_ok, plot_drop;
   logic                we;
   logic [AW-1:0]       waddr;
   logic [COLOUR_W-1:0] wdata;

`ifdef FB_BOUNDS_CHECK_EN
   assign in_range = (32'(vga_x) < WIDTH) && (32'(vga_y) < HEIGHT);
`else
   assign in_range = 1'b1;
`endif

   assign plot_ok   = vga_plot && (state != CLEAR) && in_range;
   assign plot_drop = vga_plot && !plot_ok;

   always_comb begin
      we    = plot_ok;
      waddr = AW'(fb_addr(vga_x, vga_y, WIDTH, DEPTH));
      wdata = vga_colour;
      if (state == CLEAR) begin
         we    = 1'b1;
         waddr = clr_addr;
         wdata = '0;
      end
   end

   fb_ram #(.DEPTH(DEPTH), .AW(AW), .DW(COLOUR_W)) u_ram (
      .clk   (clk),
      .we    (we),
      .waddr (waddr),
      .wdata (wdata),
      .re    (re),
      .raddr (iss_addr),
      .rdata (ram_rdata)
   );

   // Stage A is the RAM output register; S catches A when the consumer stalls,
   // so the read enable never depends combinationally on rd_ready.
   assign re        = (state == READ) && iss_more && !s_valid;
   assign rd_valid  = a_valid || s_valid;
   assign rd_x      = s_valid ? s_x : a_x;
   assign rd_y      = s_valid ? s_y : a_y;
   assign rd_colour = s_valid ? s_colour : (a_valid ? ram_rdata : '0);
   assign xfer      = rd_valid && rd_ready;
   assign busy      = (state != IDLE);

   always_comb begin
      state_next = state;
      done_next  = 1'b0;
      unique case (state)
         IDLE: begin
            if (clear)         state_next = CLEAR;
            else if (rd_start) state_next = READ;
         end
         CLEAR: begin
            if (clr_addr == LAST_ADDR) begin
               state_next = IDLE;
               done_next  = 1'b1;
            end
         end
         READ: begin
            if (xfer && rd_x == LAST_X && rd_y == LAST_Y) begin
               state_next = IDLE;
               done_next  = 1'b1;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         done       <= 1'b0;
         clr_addr   <= '0;
         iss_addr   <= '0;
         iss_x      <= '0;
         iss_y      <= '0;
         iss_more   <= 1'b0;
         a_valid    <= 1'b0;
         a_x        <= '0;
         a_y        <= '0;
         s_valid    <= 1'b0;
         s_x        <= '0;
         s_y        <= '0;
         s_colour   <= '0;
         plot_count <= '0;
         drop_err   <= 1'b0;
      end else begin
         state <= state_next;
         done  <= done_next;

         if (state == IDLE && clear) begin
            plot_count <= '0;
            drop_err   <= 1'b0;
            clr_addr   <= '0;
         end else begin
            if (plot_ok && plot_count != '1) plot_count <= plot_count + 15'd1;
            if (plot_drop) drop_err <= 1'b1;
         end
         if (state == CLEAR) clr_addr <= clr_addr + AW'(1);

         if (state == IDLE && !clear && rd_start) begin
            iss_addr <= '0;
            iss_x    <= '0;
            iss_y    <= '0;
            iss_more <= 1'b1;
         end else if (re) begin
            iss_more <= (iss_addr != LAST_ADDR);
            iss_addr <= iss_addr + AW'(1);
            if (iss_x == LAST_X) begin
               iss_x <= '0;
               iss_y <= iss_y + 7'd1;
            end else begin
               iss_x <= iss_x + 8'd1;
            end
         end

         a_valid <= re || (s_valid && a_valid);
         if (re) begin
            a_x <= iss_x;
            a_y <= iss_y;
         end
         if (s_valid) begin
            if (xfer) s_valid <= 1'b0;
         end else if (a_valid && !xfer) begin
            s_valid  <= 1'b1;
            s_x      <= a_x;
            s_y      <= a_y;
            s_colour <= ram_rdata;
         end
      end
   end
endmodule
